bit_population_generator: RTL and testbench
===========================================

# bit_population_generator

Stimulus-side counterpart of `bit_population_counter`. It accepts a requested population count and emits a WIDTH-bit word with exactly that many bits set. Bit positions are chosen pseudo-randomly by a free-running LFSR. The block sits upstream of the counter, in directed and self-checking environments, and produces the data words the counter consumes.

## Interface
Parameters:
- WIDTH, 16, output word width; power of two, 4..64.
- SEED, 16'hACE1, LFSR reset value; 0 is illegal and is replaced by 16'h0001.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  reset; asynchronous, active-high.
- cnt_i  in  $clog2(WIDTH)+1  requested number of set bits.
- cnt_val_i  in  1  request valid.
- cnt_ready_o  out  1  block can accept a request.
- data_o  out  WIDTH  generated word.
- data_val_o  out  1  data_o valid; one-cycle pulse.
- err_o  out  1  sticky self-check error (see Configuration).

## Operation
- State machine with two states, IDLE and FILL. cnt_ready_o = (state == IDLE).
- Accept: a request is accepted on a rising edge with cnt_val_i && cnt_ready_o. cnt_val_i while in FILL is ignored; there is no queueing.
- On accept:
  - t = min(cnt_i, WIDTH); values above WIDTH saturate.
  - inv = (t > WIDTH/2).
  - n = inv ? WIDTH - t : t, so n ≤ WIDTH/2.
  - work word cleared to 0; placed counter cleared; state -> FILL.
- FILL, each cycle while placed < n:
  - p = lfsr[$clog2(WIDTH)-1:0].
  - If work[p] is 0, set bit p.
  - Otherwise set the first clear bit scanning upward from p+1 with wrap to bit 0. This is a combinational priority search.
  - placed increments by exactly 1 per cycle.
- FILL, cycle with placed == n (this includes n == 0):
  - data_o <= inv ? ~work : work.
  - data_val_o <= 1.
  - state -> IDLE.
- LFSR: 16-bit Galois, taps 16'hB400. Reset to SEED. Advances every clock regardless of state.
- data_o holds its last value until the next result. data_val_o is high for exactly one cycle per accepted request.
- Invariant: popcount(data_o) == t for every data_val_o pulse.

## Timing
- Reset values: state IDLE, cnt_ready_o=1, data_o=0, data_val_o=0, err_o=0, LFSR=SEED.
- Latency: accept on edge E0 gives data_val_o high in the cycle following edge E0+n+1.
  - t=0 or t=WIDTH: 1 cycle.
  - Worst case t=WIDTH/2: WIDTH/2+1 cycles.
- cnt_ready_o rises in the same cycle data_val_o is high. A new request can be accepted on the edge that ends the data_val_o cycle, so back-to-back requests incur no bubble.
- arst_i asserted mid-FILL:
  - aborts immediately and returns all outputs to reset values;
  - no data_val_o is produced for the aborted request.
- Collision with all remaining bits set cannot occur, because n ≤ WIDTH/2 guarantees a clear bit exists.

## Configuration
- BIT_POP_GEN_SELFCHECK_EN defined:
  - Adds a registered popcount of the output word, compared against the latched t one cycle after each data_val_o.
  - On mismatch, err_o sets and stays high until arst_i.
- Undefined:
  - No checker logic is built.
  - err_o is tied to 0.

## Test plan
All scenarios use WIDTH=16.
- Reset release, then cnt_i=0 valid one cycle -> data_o=16'h0000, data_val_o pulse 1 cycle after accept, cnt_ready_o low for 1 cycle.
- cnt_i=16 -> data_o=16'hFFFF after 1 cycle. cnt_i=31 (saturates) -> data_o=16'hFFFF.
- cnt_i=8 -> data_val_o 9 cycles after accept, popcount(data_o)=8. cnt_i=12 -> 5 cycles, popcount 12. cnt_i=3 -> 4 cycles, popcount 3.
- Sweep cnt_i 0..16 back-to-back with cnt_val_i held high:
  - each request accepted on the data_val_o cycle of the previous one;
  - 17 pulses total;
  - feeding data_o into bit_population_counter returns cnt_i each time;
  - err_o=0 with BIT_POP_GEN_SELFCHECK_EN defined.
- cnt_val_i pulsed mid-FILL with cnt_i=5 while processing cnt_i=7 -> ignored; only one result, popcount 7.
- arst_i asserted 3 cycles into a cnt_i=8 request -> data_val_o never asserts; after release cnt_ready_o=1, data_o=0, and the LFSR restarts from SEED, so repeated identical stimulus gives an identical data_o sequence.

Source files
------------

// File: rtl/bit_population_generator.sv
// Emits a WIDTH-bit word with exactly the requested number of bits set, positions from a 16-bit Galois LFSR.
// Optional output self-check: define BIT_POP_GEN_SELFCHECK_EN to build it (err_o tied low otherwise).
module bit_population_generator #(
    parameter int          WIDTH = 16,
    parameter logic [15:0] SEED  = 16'hACE1
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic [$clog2(WIDTH):0]   cnt_i,
    input  logic                     cnt_val_i,
    output logic                     cnt_ready_o,
    output logic [WIDTH-1:0]         data_o,
    output logic                     data_val_o,
    output logic                     err_o
);

    localparam int           LW       = $clog2(WIDTH);
    localparam logic [15:0]  SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0]  TAPS     = 16'hB400;
    localparam logic [LW:0]  FULL     = (LW+1)'(WIDTH);
    localparam logic [LW:0]  HALF     = (LW+1)'(WIDTH / 2);

    typedef enum logic {IDLE, FILL} state_t;

    function automatic logic [LW:0] sat_cnt(input logic [LW:0] c);
        return (c > FULL) ? FULL : c;
    endfunction

    function automatic logic [LW:0] popcount(input logic [WIDTH-1:0] w);
        logic [LW:0] pc;
        pc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            pc = pc + (LW+1)'(w[i]);
        end
        return pc;
    endfunction

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [LW:0]       placed_q, placed_d;
    logic [LW:0]       n_q, n_d;
    logic              inv_q, inv_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              dval_q, dval_d;
    logic [15:0]       lfsr_q, lfsr_d;

    logic [LW:0]       t_sat;
    logic              inv_acc;
    logic [LW:0]       n_acc;
    logic [LW-1:0]     pos;
    logic [LW-1:0]     sel;
    logic              accept;

    assign t_sat   = sat_cnt(cnt_i);
    assign inv_acc = (t_sat > HALF);
    assign n_acc   = inv_acc ? (FULL - t_sat) : t_sat;
    assign accept  = (state_q == IDLE) && cnt_val_i;
    assign pos     = lfsr_q[LW-1:0];

    // First clear bit at or above pos, wrapping through bit 0; the LW-bit add wraps for free.
    always_comb begin
        logic          found;
        logic [LW-1:0] idx;
        sel   = pos;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            idx = pos + LW'(i);
            if (!found && !work_q[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        placed_d = placed_q;
        n_d      = n_q;
        inv_d    = inv_q;
        data_d   = data_q;
        dval_d   = 1'b0;
        lfsr_d   = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
        case (state_q)
            IDLE: begin
                if (cnt_val_i) begin
                    inv_d    = inv_acc;
                    n_d      = n_acc;
                    work_d   = '0;
                    placed_d = '0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (placed_q == n_q) begin
                    data_d  = inv_q ? ~work_q : work_q;
                    dval_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    work_d[sel] = 1'b1;
                    placed_d    = placed_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q  <= IDLE;
            work_q   <= '0;
            placed_q <= '0;
            n_q      <= '0;
            inv_q    <= 1'b0;
            data_q   <= '0;
            dval_q   <= 1'b0;
            lfsr_q   <= SEED_EFF;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            placed_q <= placed_d;
            n_q      <= n_d;
            inv_q    <= inv_d;
            data_q   <= data_d;
            dval_q   <= dval_d;
            lfsr_q   <= lfsr_d;
        end
    end

    assign cnt_ready_o = (state_q == IDLE);
    assign data_o      = data_q;
    assign data_val_o  = dval_q;

`ifdef BIT_POP_GEN_SELFCHECK_EN
    logic [LW:0] t_q;
    logic [LW:0] chk_t_q;
    logic [LW:0] pc_q;
    logic        chk_pend_q;
    logic        err_q;

    // The target is copied at the result pulse so a back-to-back accept cannot disturb the compare.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            t_q        <= '0;
            chk_t_q    <= '0;
            pc_q       <= '0;
            chk_pend_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            if (accept) begin
                t_q <= t_sat;
            end
            if (dval_q) begin
                pc_q    <= popcount(data_q);
                chk_t_q <= t_q;
            end
            chk_pend_q <= dval_q;
            if (chk_pend_q && (pc_q != chk_t_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bit_population_generator.sv
// Directed bench for bit_population_generator at WIDTH=16: exact words, popcounts, latencies, back-to-back, abort.
module tb_bit_population_generator;

    localparam int W = 16;

    logic        clk = 1'b0;
    logic        arst;
    logic [4:0]  cnt;
    logic        cnt_val;
    logic        ready;
    logic [15:0] data;
    logic        dval;
    logic        err;

    int n_cmp = 0;
    int n_bad = 0;

    bit_population_generator #(.WIDTH(W), .SEED(16'hACE1)) dut (
        .clk_i       (clk),
        .arst_i      (arst),
        .cnt_i       (cnt),
        .cnt_val_i   (cnt_val),
        .cnt_ready_o (ready),
        .data_o      (data),
        .data_val_o  (dval),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pop16(input logic [15:0] w);
        int s = 0;
        for (int i = 0; i < 16; i++) s += int'(w[i]);
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst    = 1'b1;
        cnt_val = 1'b0;
        cnt     = '0;
        tick();
        tick();
        arst = 1'b0;
        #1;
        chk("rst_ready", ready, 1);
        chk("rst_data", data, 0);
        chk("rst_dval", dval, 0);
        chk("rst_err", err, 0);
    endtask

    // Issues one request from IDLE and waits for its result pulse.
    task automatic req(input int c, input int exp_lat, output logic [15:0] word);
        int cyc;
        int tsat;
        tsat    = (c > W) ? W : c;
        cnt     = 5'(c);
        cnt_val = 1'b1;
        tick();
        cnt_val = 1'b0;
        chk($sformatf("rdy_low_%0d", c), ready, 0);
        cyc = 0;
        while (!dval && cyc < 40) begin
            tick();
            cyc++;
        end
        chk($sformatf("lat_%0d", c), cyc, exp_lat);
        chk($sformatf("pop_%0d", c), pop16(data), tsat);
        chk($sformatf("rdy_on_val_%0d", c), ready, 1);
        word = data;
        tick();
        chk($sformatf("pulse_len_%0d", c), dval, 0);
        chk($sformatf("hold_%0d", c), data, word);
    endtask

    function automatic int lat_of(input int c);
        int t = (c > W) ? W : c;
        int n = (t > W/2) ? W - t : t;
        return n + 1;
    endfunction

    initial begin
        logic [15:0] w;
        logic [15:0] a1, a2, b1, b2;
        int vec_c   [8] = '{0, 16, 31, 8, 12, 3, 1, 15};
        int vec_lat [8] = '{1,  1,  1, 9,  5, 4, 2,  2};
        int pulses, c, gap, budget, cyc, extra;

        do_reset();

        // Directed requests with hand-derived latencies.
        for (int i = 0; i < 8; i++) begin
            req(vec_c[i], vec_lat[i], w);
            if (vec_c[i] == 0) chk("word_zero", w, 16'h0000);
            if (vec_c[i] >= 16) chk($sformatf("word_full_%0d", vec_c[i]), w, 16'hFFFF);
        end

        // Back-to-back sweep with cnt_val held high.
        pulses  = 0;
        c       = 0;
        gap     = 0;
        budget  = 0;
        cnt     = 5'd0;
        cnt_val = 1'b1;
        while (pulses < 17 && budget < 600) begin
            tick();
            budget++;
            gap++;
            if (dval) begin
                chk($sformatf("sweep_pop_%0d", c), pop16(data), c);
                chk($sformatf("sweep_gap_%0d", c), gap, lat_of(c) + 1);
                chk($sformatf("sweep_rdy_%0d", c), ready, 1);
                pulses++;
                c++;
                cnt = 5'(c);
                gap = 0;
            end
        end
        cnt_val = 1'b0;
        chk("sweep_pulses", pulses, 17);
        tick();
        tick();
        tick();
        chk("sweep_err", err, 0);

        // Request while busy must be dropped.
        cnt     = 5'd7;
        cnt_val = 1'b1;
        tick();
        cnt_val = 1'b0;
        cyc = 0;
        tick(); cyc++;
        tick(); cyc++;
        cnt     = 5'd5;
        cnt_val = 1'b1;
        tick(); cyc++;
        cnt_val = 1'b0;
        while (!dval && cyc < 40) begin
            tick();
            cyc++;
        end
        chk("busy_lat", cyc, 8);
        chk("busy_pop", pop16(data), 7);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dval) extra++;
        end
        chk("busy_extra", extra, 0);

        // Asynchronous reset mid-FILL.
        cnt     = 5'd8;
        cnt_val = 1'b1;
        tick();
        cnt_val = 1'b0;
        tick();
        tick();
        tick();
        arst = 1'b1;
        #1;
        chk("abort_ready", ready, 1);
        chk("abort_data", data, 0);
        chk("abort_dval", dval, 0);
        tick();
        arst = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (dval) extra++;
        end
        chk("abort_no_pulse", extra, 0);
        chk("abort_ready_after", ready, 1);
        chk("abort_data_after", data, 0);

        // LFSR restarts from SEED: identical stimulus after reset gives identical words.
        do_reset();
        req(5, 6, a1);
        req(9, 8, b1);
        do_reset();
        req(5, 6, a2);
        req(9, 8, b2);
        chk("repeat_a", a2, a1);
        chk("repeat_b", b2, b1);
        chk("final_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
